// File: rtl/pipelined_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_barrel_shifter                                                   |
// | Shift/rotate WIDTH-bit words, one log2 stage per clock, valid/ready flow.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH)-1:0]   in_shift,
  input  logic                       in_dir,
  input  logic [1:0]                 in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [1:0] c_mode_arith  = 2'b01;
  localparam logic [1:0] c_mode_rotate = 2'b10;

  logic [WIDTH-1:0]   r_data  [SHAMT_W];
  logic [SHAMT_W-1:0] r_shift [SHAMT_W];
  logic [1:0]         r_mode  [SHAMT_W];
  logic [SHAMT_W-1:0] r_valid;
  logic [SHAMT_W-1:0] r_dir;
  logic [SHAMT_W-1:0] r_sign;
  logic               r_zero;

  logic [WIDTH-1:0]   w_prev_data  [SHAMT_W];
  logic [SHAMT_W-1:0] w_prev_shift [SHAMT_W];
  logic [1:0]         w_prev_mode  [SHAMT_W];
  logic [SHAMT_W-1:0] w_prev_valid;
  logic [SHAMT_W-1:0] w_prev_dir;
  logic [SHAMT_W-1:0] w_prev_sign;
  logic [WIDTH-1:0]   w_res        [SHAMT_W];
  logic               w_advance;

  // Fixed-distance step; the sign travels with the operand so that
  // arithmetic fill always uses the original MSB, not the partial result.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v,
                                            input int unsigned      d,
                                            input logic             dir,
                                            input logic [1:0]       mode,
                                            input logic             sign);
    logic [WIDTH-1:0] fill;
    fill = (dir && mode == c_mode_arith && sign) ? ~({WIDTH{1'b1}} >> d) : '0;
    if (mode == c_mode_rotate)
      step = dir ? ((v >> d) | (v << (WIDTH - d))) : ((v << d) | (v >> (WIDTH - d)));
    else
      step = dir ? ((v >> d) | fill) : (v << d);
  endfunction

  assign w_advance = !r_valid[SHAMT_W-1] || out_ready;
  assign in_ready  = w_advance && rst_n;
  assign out_valid = r_valid[SHAMT_W-1];
  assign out_data  = r_data[SHAMT_W-1];
  assign out_zero  = r_zero;

  always_comb begin
    w_prev_data  = '{default: '0};
    w_prev_shift = '{default: '0};
    w_prev_mode  = '{default: '0};
    w_res        = '{default: '0};
    w_prev_valid = '0;
    w_prev_dir   = '0;
    w_prev_sign  = '0;
    w_prev_data[0]  = in_data;
    w_prev_shift[0] = in_shift;
    w_prev_mode[0]  = in_mode;
    w_prev_valid[0] = in_valid;
    w_prev_dir[0]   = in_dir;
    w_prev_sign[0]  = in_data[WIDTH-1];
    for (int k = 1; k < SHAMT_W; k++) begin
      w_prev_data[k]  = r_data[k-1];
      w_prev_shift[k] = r_shift[k-1];
      w_prev_mode[k]  = r_mode[k-1];
      w_prev_valid[k] = r_valid[k-1];
      w_prev_dir[k]   = r_dir[k-1];
      w_prev_sign[k]  = r_sign[k-1];
    end
    for (int k = 0; k < SHAMT_W; k++) begin
      w_res[k] = w_prev_shift[k][k]
               ? step(w_prev_data[k], 32'd1 << k, w_prev_dir[k], w_prev_mode[k], w_prev_sign[k])
               : w_prev_data[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dir   <= '0;
      r_sign  <= '0;
      r_zero  <= 1'b0;
      for (int k = 0; k < SHAMT_W; k++) begin
        r_data[k]  <= '0;
        r_shift[k] <= '0;
        r_mode[k]  <= '0;
      end
    end else if (w_advance) begin
      r_valid <= w_prev_valid;
      r_dir   <= w_prev_dir;
      r_sign  <= w_prev_sign;
      r_zero  <= (w_res[SHAMT_W-1] == '0);
      for (int k = 0; k < SHAMT_W; k++) begin
        r_data[k]  <= w_res[k];
        r_shift[k] <= w_prev_shift[k];
        r_mode[k]  <= w_prev_mode[k];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipelined_barrel_shifter                                                |
// | Directed stimulus with an expected-result queue for the pipelined shifter. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipelined_barrel_shifter;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [3:0]    in_shift;
  logic          in_dir;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_zero;

  typedef struct {
    logic [W-1:0] d;
    logic         z;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pops  = 0;
  int   cyc   = 0;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bit-by-bit reference: each result bit picks its source bit directly.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int s,
                                         input logic dir, input logic [1:0] mode);
    logic [W-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (!dir) begin
        j = i - s;
        if (j >= 0)            r[i] = d[j];
        else if (mode == 2'b10) r[i] = d[j + W];
        else                   r[i] = 1'b0;
      end else begin
        j = i + s;
        if (j < W)             r[i] = d[j];
        else if (mode == 2'b10) r[i] = d[j - W];
        else if (mode == 2'b01) r[i] = d[W-1];
        else                   r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic send(input logic [W-1:0] d, input int s, input logic dir, input logic [1:0] mode);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_shift = s[3:0];
    in_dir   = dir;
    in_mode  = mode;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(negedge clk);
      #1;
    end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    e.d = model(d, s, dir, mode);
    e.z = (e.d == '0);
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", q.size(), 32'd0);
  endtask

  // Scoreboard side: a result shown with out_ready high is consumed at the next edge.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("extra_result", {31'b0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        check("result_data", {16'b0, out_data}, {16'b0, e.d});
        check("result_zero", {31'b0, out_zero}, {31'b0, e.z});
        pops++;
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    logic         heldz;
    int           n;
    int           c0;
    int           p0;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0;
    in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_data", {16'b0, out_data}, 32'd0);
    check("reset_out_zero", {31'b0, out_zero}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", {31'b0, in_ready}, 32'd1);

    // Latency of the first operand
    send(16'hAAAA, 4, 1'b0, 2'b00);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_edges_after_accept", n, 32'd3);
    drain();

    send(16'h0033, 8, 1'b0, 2'b00);
    send(16'h8F0F, 4, 1'b1, 2'b01);
    send(16'h8F0F, 4, 1'b1, 2'b00);
    send(16'h8F0F, 4, 1'b1, 2'b11);
    send(16'h8F0F, 4, 1'b0, 2'b01);
    send(16'h0F0F, 15, 1'b1, 2'b10);
    send(16'hF0F0, 1, 1'b0, 2'b10);
    for (int m = 0; m < 4; m++) begin
      send(16'hA5A5, 0, 1'b0, m[1:0]);
      send(16'hA5A5, 0, 1'b1, m[1:0]);
    end
    send(16'h0001, 15, 1'b0, 2'b00);
    send(16'h00F0, 12, 1'b0, 2'b00);
    send(16'h8001, 15, 1'b1, 2'b01);
    send(16'h8001, 15, 1'b0, 2'b10);
    drain();

    // Backpressure: 3-cycle stall with a full pipeline
    for (int i = 0; i < 4; i++)
      send(W'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 2'($urandom));
    check("bp_valid_at_stall", {31'b0, out_valid}, 32'd1);
    out_ready = 1'b0;
    held  = out_data;
    heldz = out_zero;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
      check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      check("bp_out_data_held", {16'b0, out_data}, {16'b0, held});
      check("bp_out_zero_held", {31'b0, out_zero}, {31'b0, heldz});
    end
    out_ready = 1'b1;
    c0 = cyc;
    p0 = pops;
    for (int i = 0; i < 4; i++)
      send(W'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 2'($urandom));
    check("bp_accept_rate", cyc - c0, 32'd4);
    repeat (4) @(posedge clk);
    #1;
    check("bp_throughput_pops", pops - p0, 32'd8);
    drain();

    // Reset with three operands in flight
    send(16'h1234, 3, 1'b0, 2'b00);
    send(16'h5678, 5, 1'b1, 2'b01);
    send(16'h9ABC, 7, 1'b0, 2'b10);
    q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_no_stale", {31'b0, out_valid}, 32'd0);
    end

    send(16'hC003, 2, 1'b1, 2'b01);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
